// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the auto-clearing register file.
package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every register index once after reset or on request,
// holding Busy high until the final index has been written.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ClearReq,
    output logic              Busy,
    output logic [ADDR_W-1:0] ClrIdx,
    output logic              ClrWe
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic              busy_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= CLEAR;
            ClrIdx <= '0;
            Busy   <= 1'b1;
        end else begin
            state  <= state_nxt;
            ClrIdx <= idx_nxt;
            Busy   <= busy_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = ClrIdx;
        busy_nxt  = Busy;
        ClrWe     = 1'b0;
        case (state)
            CLEAR: begin
                ClrWe   = 1'b1;
                idx_nxt = ClrIdx + ADDR_W'(1);  // wraps to 0 on the terminal write
                if (ClrIdx == LAST_IDX) begin
                    state_nxt = READY;
                    busy_nxt  = 1'b0;
                end
            end
            READY: begin
                if (ClearReq) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
                idx_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_autoclear.sv
// 2-read/1-write register file with register 0 hard-wired to zero and a clear sweep.
// Optional write-through read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_autoclear
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic              ClearReq,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_we;
    logic              port_we;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ClearReq (ClearReq),
        .Busy     (Busy),
        .ClrIdx   (clr_idx),
        .ClrWe    (clr_we)
    );

    // A clear request in READY drops a coincident port write.
    assign port_we = !Busy && RegWrite && (WriteRegister != '0) && !ClearReq;

    // NOTE: the array has no reset; its contents are zeroed by the clear sweep instead.
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (port_we) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (WriteRegister != '0) && (WriteRegister == ReadRegister1))
            ReadData1 = WriteData;
        if (RegWrite && (WriteRegister != '0) && (WriteRegister == ReadRegister2))
            ReadData2 = WriteData;
`endif
        // Busy and address 0 take priority over array contents and bypass.
        if (Busy || (ReadRegister1 == '0)) ReadData1 = '0;
        if (Busy || (ReadRegister2 == '0)) ReadData2 = '0;
    end

endmodule

// File: tb/tb_regfile_autoclear.sv
// Self-checking bench for regfile_autoclear: vector table, clear/reset corner
// sequences, and randomized traffic against a behavioural model.
module tb_regfile_autoclear;

    localparam int DEPTH = 32;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, ClearReq, Busy;

    int tests = 0;
    int fails = 0;

    regfile_autoclear dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ClearReq      (ClearReq),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] model [DEPTH];
    int          busy_left;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Runs until Busy drops, checking reads stay zero and writes are ignored.
    task automatic sweep(input int pulse_at, output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            ReadRegister1 = 5'($urandom_range(31));
            ReadRegister2 = 5'($urandom_range(31));
            WriteRegister = 5'($urandom_range(31));
            WriteData     = $urandom;
            RegWrite      = 1'b1;
            ClearReq      = (n == pulse_at);
            #1;
            check("sweep_rd1_zero", ReadData1, 32'h0);
            check("sweep_rd2_zero", ReadData2, 32'h0);
            step();
            n++;
        end
        RegWrite = 1'b0;
        ClearReq = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input logic busy,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd, input logic [31:0] stored);
        if (busy || addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 0 && wa == addr) return wd;
`endif
        return stored;
    endfunction

    initial begin
        int n;

        Reset_n = 1'b0;
        ReadRegister1 = '0; ReadRegister2 = '0; WriteRegister = '0;
        WriteData = '0; RegWrite = 1'b0; ClearReq = 1'b0;

        // Reset and initial sweep.
        repeat (3) step();
        check("reset_busy", 32'(Busy), 32'h1);
        check("reset_rd1", ReadData1, 32'h0);
        Reset_n = 1'b1;
        sweep(-1, n);
        check("reset_sweep_len", n, 32);
        for (int i = 0; i < DEPTH; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(DEPTH - 1 - i);
            #1;
            check("post_clear_rd1", ReadData1, 32'h0);
            check("post_clear_rd2", ReadData2, 32'h0);
        end

        // Vector table: writes, reg-0 discard, write-enable leak, neighbour isolation.
        for (int i = 1; i < DEPTH; i++)
            vecs.push_back('{1'b1, 5'(i), 32'(i), 5'(i), 5'(i), 32'(i), 32'(i)});
        vecs.push_back('{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0});
        for (int i = 1; i < DEPTH; i++)
            vecs.push_back('{1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(i), 32'(i), 32'(i)});
        vecs.push_back('{1'b1, 5'd5, 32'hFFFF_FFFF, 5'd4, 5'd6, 32'd4, 32'd6});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 32'd3, 32'd31});
        foreach (vecs[k]) begin
            RegWrite      = vecs[k].we;
            WriteRegister = vecs[k].wa;
            WriteData     = vecs[k].wd;
            ReadRegister1 = vecs[k].r1;
            ReadRegister2 = vecs[k].r2;
            step();
            check("vec_rd1", ReadData1, vecs[k].e1);
            check("vec_rd2", ReadData2, vecs[k].e2);
        end
        RegWrite = 1'b0;

        // Clear request wins over a coincident write; a mid-sweep request does not extend it.
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hA5; ClearReq = 1'b1;
        step();
        RegWrite = 1'b0; ClearReq = 1'b0;
        check("clr_busy_rise", 32'(Busy), 32'h1);
        sweep(10, n);
        check("clr_sweep_len", n, 32);
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
        #1;
        check("clr_reg7", ReadData1, 32'h0);
        check("clr_reg8", ReadData2, 32'h0);

        // Reset mid-sweep restarts the full sweep.
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        repeat (15) step();
        check("midsweep_busy", 32'(Busy), 32'h1);
        Reset_n = 1'b0;
        repeat (2) step();
        Reset_n = 1'b1;
        sweep(-1, n);
        check("restart_sweep_len", n, 32);

        // Pre-edge read of a same-cycle write (bypass build shows the new data).
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h1234;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("preedge_rd1", ReadData1, 32'h1234);
`else
        check("preedge_rd1", ReadData1, 32'h0);
`endif
        check("preedge_rd2", ReadData2, 32'h0);
        step();
        RegWrite = 1'b0;
        #1;
        check("postedge_rd1", ReadData1, 32'h1234);

        // Randomized traffic against the behavioural model.
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        sweep(-1, n);
        check("rand_prep_sweep_len", n, 32);
        foreach (model[i]) model[i] = 32'h0;
        busy_left = 0;
        for (int it = 0; it < 400; it++) begin
            ReadRegister1 = 5'($urandom_range(31));
            ReadRegister2 = 5'($urandom_range(31));
            WriteRegister = ($urandom_range(3) == 0) ? ReadRegister1 : 5'($urandom_range(31));
            WriteData     = $urandom;
            RegWrite      = 1'($urandom_range(1));
            ClearReq      = ($urandom_range(59) == 0);
            #1;
            check("rand_rd1", ReadData1, exp_read(ReadRegister1, busy_left > 0, RegWrite,
                  WriteRegister, WriteData, model[ReadRegister1]));
            check("rand_rd2", ReadData2, exp_read(ReadRegister2, busy_left > 0, RegWrite,
                  WriteRegister, WriteData, model[ReadRegister2]));
            check("rand_busy", 32'(Busy), 32'(busy_left > 0));
            @(posedge Clk);
            if (busy_left > 0) begin
                busy_left--;
            end else if (ClearReq) begin
                busy_left = DEPTH;
                foreach (model[i]) model[i] = 32'h0;
            end else if (RegWrite && WriteRegister != 0) begin
                model[WriteRegister] = WriteData;
            end
            #1;
        end
        RegWrite = 1'b0;
        ClearReq = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
